div_restoring_n: RTL

Parametrised sequential integer divider: restoring shift-subtract, one quotient bit per clock, with selectable signed/unsigned operation per transaction. It generalises the earlier fixed 16-bit repeated-subtraction divider in four ways:
- data-independent latency;
- parallel operand load instead of serial load;
- explicit start/busy/done handshake;
- defined divide-by-zero behaviour.

It sits in the arithmetic datapath as a drop-in unit, addressed by a controller that issues one division at a time.

---
 rtl/div_pkg.sv | 10 +
 rtl/div_step.sv | 17 +
 rtl/div_restoring_n.sv | 78 +++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared FSM state, counter sizing and negate helper for the restoring divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  function automatic int cnt_w(int w);
    return $clog2(w) + 1;
  endfunction
  function automatic logic [63:0] cneg(logic [63:0] v, logic n);
    return n ? -v : v;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring shift-subtract iteration
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);
  logic [WIDTH:0] sh, trial;
  // rem < div always holds, so the W+1-bit difference never overflows its sign bit
  assign sh      = {rem, quo[WIDTH-1]};
  assign trial   = sh - {1'b0, div};
  assign rem_nxt = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/div_restoring_n.sv
// div_restoring_n: sequential signed/unsigned restoring divider, one quotient bit per clock
module div_restoring_n
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CNT_W = cnt_w(WIDTH);
  state_t state, state_nxt;
  logic [WIDTH-1:0] rem, quo, div, rem_s, quo_s;
  logic [CNT_W-1:0] cnt;
  logic qn, rn, dz_in, last;
  div_step #(.WIDTH(WIDTH)) u_step (.rem(rem), .quo(quo), .div(div), .rem_nxt(rem_s), .quo_nxt(quo_s));
  assign dz_in = divisor == '0;
  assign last  = cnt == CNT_W'(WIDTH - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE ? (start ? (dz_in ? DONE : CALC) : IDLE) :
                state == CALC ? (last ? FIX : CALC) :
                state == FIX  ? DONE : IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  // Datapath: the sign fix-ups are folded into qn/rn at capture time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem         <= '0;
      quo         <= '0;
      div         <= '0;
      cnt         <= '0;
      qn          <= 1'b0;
      rn          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        qn  <= signed_en & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        rn  <= signed_en & dividend[WIDTH-1];
        quo <= WIDTH'(cneg(64'(dividend), signed_en & dividend[WIDTH-1]));
        div <= WIDTH'(cneg(64'(divisor), signed_en & divisor[WIDTH-1]));
        rem <= '0;
        cnt <= '0;
        if (dz_in) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end
      end
      if (state == CALC) begin
        rem <= rem_s;
        quo <= quo_s;
        cnt <= cnt + 1'b1;
      end
      if (state == FIX) begin
        quotient    <= WIDTH'(cneg(64'(quo), qn));
        remainder   <= WIDTH'(cneg(64'(rem), rn));
        div_by_zero <= 1'b0;
      end
    end
  end
endmodule
